// File: rtl/usb_rx_timer.sv
// Bit-timing recovery for the USB receive path: tracks bit phase from D+ edges,
// issues sample strobes, counts bits per byte and flags mistimed or missing edges.
//
// state  | meaning
// IDLE   | outside a packet; phase, bit count and gap count held at zero
// ACTIVE | inside a packet; phase free-runs and resyncs on every edge
module usb_rx_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       rcving,
  input  logic       clear,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [2:0] bit_count,
  output logic       timing_err,
  output logic       no_edge_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [3:0] LAST_PH = 4'(CLKS_PER_BIT - 1);
  localparam logic [3:0] SAMPLE  = 4'(SAMPLE_PT);
  localparam logic [3:0] WIN_HI  = 4'(CLKS_PER_BIT - SAMPLE_PT);
  localparam logic [3:0] GAP_MAX = 4'd8;

  logic [0:0] state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [2:0] bit_count_q, bit_count_d;
  logic [3:0] gap_q, gap_d;
  logic       timing_err_q, timing_err_d;
  logic       no_edge_err_q, no_edge_err_d;

  assign shift_enable  = (state_q == ACTIVE) && rcving && (phase_q == SAMPLE);
  assign byte_received = shift_enable && (bit_count_q == 3'd7);
  assign bit_count     = bit_count_q;
  assign timing_err    = timing_err_q;
  assign no_edge_err   = no_edge_err_q;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    bit_count_d   = bit_count_q;
    gap_d         = gap_q;
    timing_err_d  = 1'b0;
    no_edge_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d     = 4'd0;
        bit_count_d = 3'd0;
        gap_d       = 4'd0;
        if (rcving && d_edge) begin
          state_d = ACTIVE;
          phase_d = 4'd1;
        end
      end
      ACTIVE: begin
        if (!rcving) begin
          state_d     = IDLE;
          phase_d     = 4'd0;
          bit_count_d = 3'd0;
          gap_d       = 4'd0;
        end else begin
          // The edge cycle itself counts as phase 0, so the next cycle is phase 1.
          if (d_edge) begin
            phase_d = 4'd1;
          end else if (phase_q == LAST_PH) begin
            phase_d = 4'd0;
          end else begin
            phase_d = phase_q + 4'd1;
          end

          if (clear) begin
            bit_count_d = 3'd0;
          end else if (shift_enable) begin
            bit_count_d = bit_count_q + 3'd1;
          end

          if (d_edge) begin
            gap_d = 4'd0;
          end else if (shift_enable && (gap_q != GAP_MAX)) begin
            gap_d = gap_q + 4'd1;
          end

          timing_err_d  = d_edge && (phase_q >= SAMPLE) && (phase_q <= WIN_HI);
          // Only the transition into saturation raises the flag.
          no_edge_err_d = (gap_q != GAP_MAX) && (gap_d == GAP_MAX);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      phase_q       <= 4'd0;
      bit_count_q   <= 3'd0;
      gap_q         <= 4'd0;
      timing_err_q  <= 1'b0;
      no_edge_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_count_q   <= bit_count_d;
      gap_q         <= gap_d;
      timing_err_q  <= timing_err_d;
      no_edge_err_q <= no_edge_err_d;
    end
  end

endmodule
